// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register and one-entry skid buffer.
// Optional FETCH_PERF_EN adds fetched-word and stall-cycle counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        id_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_data_q, skid_data_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        rsp_want;
    logic        load_id;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_pc4_d   = skid_pc4_q;
        id_valid_d   = id_valid_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        load_id      = 1'b0;

        imem_req = rst_n && (state_q == IDLE) && !skid_valid_q && !redirect;
        rsp_want = (state_q == WAIT) && imem_rvalid;

        // rvalid in IDLE is a protocol violation and is deliberately ignored
        unique case (state_q)
            IDLE: if (imem_req) state_d = WAIT;
            WAIT: begin
                if (imem_rvalid)   state_d = IDLE;
                else if (redirect) state_d = DROP;
            end
            DROP: if (imem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (imem_req) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
        end

        if (redirect) begin
            pc_d         = redirect_pc;
            skid_valid_d = 1'b0;
            id_valid_d   = 1'b0;
            instr_d      = NOP_INSTR;
        end else if (stall) begin
            if (rsp_want) begin
                skid_valid_d = 1'b1;
                skid_data_d  = imem_rdata;
                skid_pc4_d   = req_pc_q + 32'd4;
            end
        end else if (skid_valid_q) begin
            skid_valid_d = 1'b0;
            id_valid_d   = 1'b1;
            instr_d      = skid_data_q;
            pc4_d        = skid_pc4_q;
            load_id      = 1'b1;
        end else if (rsp_want) begin
            id_valid_d = 1'b1;
            instr_d    = imem_rdata;
            pc4_d      = req_pc_q + 32'd4;
            load_id    = 1'b1;
        end else begin
            id_valid_d = 1'b0;
            instr_d    = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_pc4_q   <= '0;
            id_valid_q   <= 1'b0;
            instr_q      <= NOP_INSTR;
            pc4_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_pc4_q   <= skid_pc4_d;
            id_valid_q   <= id_valid_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
        end
    end

    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign pc_plus4  = pc4_q;
    assign id_valid  = id_valid_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, stalls_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            stalls_q  <= '0;
        end else begin
            if (load_id)             fetched_q <= fetched_q + 32'd1;
            if (stall && !redirect)  stalls_q  <= stalls_q + 32'd1;
        end
    end

    assign perf_fetched      = fetched_q;
    assign perf_stall_cycles = stalls_q;
`else
    logic unused_load_id;
    assign unused_load_id = load_id;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode/execute datapath.
- Keeps the PC and issues single-outstanding requests to instruction memory over a req/rvalid handshake.
- Buffers returned words in a one-entry skid register while decode is stalled.
- Presents instr, pc_plus4 and id_valid to decode; handles branch redirect/flush and load-use stall.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instr value driven for bubbles/flush (sll $0,$0,0)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  one-cycle fetch request pulse
imem_addr  output  32  byte address of request; equals pc
imem_rvalid  input  1  read data valid; exactly one pulse per request, >=1 cycle after req
imem_rdata  input  32  instruction word, valid with imem_rvalid
stall  input  1  hold IF/ID (load-use hazard from decode)
redirect  input  1  taken branch/jump; flush and reload PC
redirect_pc  input  32  new fetch address, valid with redirect
instr  output  32  IF/ID instruction
pc_plus4  output  32  IF/ID PC+4 of instr
id_valid  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, skid_valid=0, id_valid=0, instr=NOP_INSTR, pc_plus4=0. imem_req=0 while rst_n=0.
- States: IDLE (no outstanding request), WAIT (request outstanding, data wanted), DROP (request outstanding, data to be discarded).
- imem_req = rst_n & (state==IDLE) & !skid_valid & !redirect. imem_addr = pc.
- On an issuing edge: req_pc<=pc; pc<=pc+4 (mod 2^32); state<=WAIT.
- WAIT + rvalid: return to IDLE.
  - !stall: IF/ID loads {imem_rdata, req_pc+4, valid=1}.
  - stall: word goes to skid {data, req_pc+4}; skid_valid=1; IF/ID held.
- IF/ID update when !stall & !redirect, in priority order:
  - skid_valid: load skid; skid_valid<=0.
  - else WAIT & rvalid: load returned word.
  - else: bubble (id_valid=0, instr=NOP_INSTR, pc_plus4 unchanged).
- stall=1 & !redirect: IF/ID holds all three outputs unchanged.
- Redirect (priority over stall and everything else), at the next edge:
  - pc<=redirect_pc; IF/ID flushed (id_valid=0, instr=NOP_INSTR); skid_valid<=0.
  - State change: WAIT&!rvalid->DROP; WAIT&rvalid->IDLE (word discarded); DROP stays DROP unless rvalid (->IDLE); IDLE stays IDLE.
  - No request in the redirect cycle; redirect_pc is issued the first cycle after, once state==IDLE.
- DROP + rvalid: word discarded, ->IDLE, IF/ID gets bubble unless stalled.
- Repeated redirects: last redirect_pc wins.
- rvalid in IDLE: ignored (protocol violation, no state change).
- Latency: memory latency L => a fetched word reaches IF/ID at the edge L cycles after req. Throughput one instruction per L+1 cycles.
- Reset mid-operation: any outstanding response after rst_n rises while state==IDLE is ignored per above rule.

Optional Feature:
- FETCH_PERF_EN defined adds outputs perf_fetched[31:0] and perf_stall_cycles[31:0].
  - perf_fetched: +1 per word loaded into IF/ID; discarded/dropped words not counted.
  - perf_stall_cycles: +1 per edge with stall=1 & !redirect.
  - Both reset to 0, wrap at 2^32.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Reset release, L=1 memory returning addr^32'hA5A5_0000: req at 0x0,0x4,0x8 every 2 cycles -> IF/ID shows 0xA5A5_0000/pc_plus4=4, then 0xA5A5_0004/8, id_valid pulses 1 per load.
- Stall asserted 3 cycles while WAIT, rvalid arrives mid-stall with 0x1234_5678 -> skid holds it, no imem_req, IF/ID unchanged; stall drops -> IF/ID=0x1234_5678 next edge, req for next pc the same cycle.
- Redirect to 0x0000_0100 while WAIT, rvalid two cycles later with 0xDEAD_BEEF -> word discarded, id_valid=0, next imem_addr=0x100.
- Redirect and stall same cycle with skid full -> skid cleared, IF/ID flushed to NOP_INSTR, id_valid=0, next req at redirect_pc.
- pc=0xFFFF_FFFC fetch -> next imem_addr=0x0000_0000, pc_plus4 of that instr=0x0.
- rst_n pulsed low mid-WAIT -> outputs immediately at reset values, late rvalid ignored, first req at RESET_PC; with FETCH_PERF_EN counters read 0.
